// File: rtl/demux_stream_buffered.sv
// 1-to-2 valid/ready demux with a 2-entry FIFO and
// a delivered-beat counter behind each output port.

module demux_stream_buffered_fifo #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [N-1:0]     din,
  output logic             full,
  output logic [N-1:0]     dout,
  output logic             valid,
  input  logic             ready,
  output logic [CNT_W-1:0] cnt
);

  logic [1:0]   occ;
  logic [N-1:0] tail;
  logic         pop;

  assign pop  = valid && ready;
  assign full = (occ == 2'd2);

  // dout is the head register; it keeps its value once drained
  always_ff @(posedge clk) begin
    if (rst) begin
      occ   <= '0;
      valid <= 1'b0;
      dout  <= '0;
      tail  <= '0;
      cnt   <= '0;
    end else begin
      if (pop) cnt <= cnt + 1'b1;
      unique case ({push, pop})
        2'b11: dout <= din;
        2'b10: begin
          if (occ == 2'd0) begin
            dout  <= din;
            valid <= 1'b1;
            occ   <= 2'd1;
          end else begin
            tail <= din;
            occ  <= 2'd2;
          end
        end
        2'b01: begin
          if (occ == 2'd2) begin
            dout <= tail;
            occ  <= 2'd1;
          end else begin
            valid <= 1'b0;
            occ   <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

module demux_stream_buffered #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  input  logic             in_choose,
  output logic             in_ready,
  output logic [N-1:0]     out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [N-1:0]     out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  logic full1, full2;
  logic push1, push2;

  assign in_ready = in_choose ? !full2 : !full1;
  assign push1    = in_valid && in_ready && !in_choose;
  assign push2    = in_valid && in_ready &&  in_choose;

  demux_stream_buffered_fifo #(.N(N), .CNT_W(CNT_W)) u_f1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .din   (in_data),
    .full  (full1),
    .dout  (out1_data),
    .valid (out1_valid),
    .ready (out1_ready),
    .cnt   (cnt1)
  );

  demux_stream_buffered_fifo #(.N(N), .CNT_W(CNT_W)) u_f2 (
    .clk   (clk),
    .rst   (rst),
    .push  (push2),
    .din   (in_data),
    .full  (full2),
    .dout  (out2_data),
    .valid (out2_valid),
    .ready (out2_ready),
    .cnt   (cnt2)
  );

endmodule

// File: tb/tb_demux_stream_buffered.sv
// Scoreboard bench for demux_stream_buffered with
// 4-bit counters so wrap-around is reachable.

module tb_demux_stream_buffered;
  localparam int N  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_data;
  logic          in_valid, in_choose, in_ready;
  logic [N-1:0]  out1_data, out2_data;
  logic          out1_valid, out2_valid;
  logic          out1_ready, out2_ready;
  logic [CW-1:0] cnt1, cnt2;

  logic [N-1:0]  q1[$];
  logic [N-1:0]  q2[$];
  logic [CW-1:0] m1, m2;
  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  demux_stream_buffered #(.N(N), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_choose  (in_choose),
    .in_ready   (in_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2_data  (out2_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .cnt1       (cnt1),
    .cnt2       (cnt2)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: compare against the model before the edge, then
  // apply the handshakes the model predicts for that edge
  task automatic step();
    logic mr;
    @(negedge clk);
    mr = (in_choose ? q2.size() : q1.size()) < 2;
    check("in_ready", in_ready, mr);
    check("out1_valid", out1_valid, q1.size() != 0);
    check("out2_valid", out2_valid, q2.size() != 0);
    check("cnt1", cnt1, m1);
    check("cnt2", cnt2, m2);
    if (rst) begin
      q1.delete();
      q2.delete();
      m1 = '0;
      m2 = '0;
    end else begin
      if (q1.size() != 0 && out1_ready) begin
        check("out1_data", out1_data, q1.pop_front());
        m1++;
      end
      if (q2.size() != 0 && out2_ready) begin
        check("out2_data", out2_data, q2.pop_front());
        m2++;
      end
      if (in_valid && mr) begin
        if (in_choose) q2.push_back(in_data);
        else           q1.push_back(in_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic c,
                       input logic [N-1:0] d);
    in_valid  = v;
    in_choose = c;
    in_data   = d;
    step();
  endtask

  initial begin
    m1 = '0;
    m2 = '0;
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_choose  = 1'b0;
    in_data    = 32'hDEAD_BEEF;
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_v1", out1_valid, 1'b0);
    check("rst_v2", out2_valid, 1'b0);
    check("rst_d1", out1_data, '0);
    check("rst_cnt1", cnt1, '0);
    check("rst_cnt2", cnt2, '0);
    check("rst_rdy0", in_ready, 1'b1);
    in_choose = 1'b1;
    #1;
    check("rst_rdy1", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // routing
    drive(1, 0, 32'hA5A5_A5A5);
    drive(1, 1, 32'h5A5A_5A5A);
    drive(0, 0, '0);
    drive(0, 0, '0);
    check("rt_cnt1", cnt1, 4'd1);
    check("rt_cnt2", cnt2, 4'd1);

    // backpressure and isolation
    out1_ready = 1'b0;
    drive(1, 0, 32'h1);
    drive(1, 0, 32'h2);
    in_data = 32'h3;
    #1;
    check("bp_full", in_ready, 1'b0);
    for (int i = 0; i < 4; i++) drive(1, 1, 32'h100 + i);
    check("bp_v1_held", out1_data, 32'h1);
    out1_ready = 1'b1;
    drive(1, 0, 32'h3);
    drive(1, 0, 32'h3);
    drive(0, 0, '0);
    drive(0, 0, '0);
    drive(0, 0, '0);

    // push and pop in the same cycle at occupancy 1
    out1_ready = 1'b0;
    drive(1, 0, 32'h66);
    out1_ready = 1'b1;
    drive(1, 0, 32'h77);
    check("pp_valid", out1_valid, 1'b1);
    check("pp_data", out1_data, 32'h77);
    drive(0, 0, '0);
    check("empty_keep", out1_data, 32'h77);

    // counter wrap
    for (int i = 0; i < 17; i++) drive(1, 0, 32'h200 + i);
    drive(0, 0, '0);
    drive(0, 0, '0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      out1_ready = 1'($urandom_range(0, 1));
      out2_ready = 1'($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    // mid-operation reset with both FIFOs full
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive(1, i[0], 32'h900 + i);
    check("mr_full1", q1.size(), 2);
    check("mr_full2", q2.size(), 2);
    rst = 1'b1;
    drive(0, 0, '0);
    rst = 1'b0;
    check("mr_v1", out1_valid, 1'b0);
    check("mr_v2", out2_valid, 1'b0);
    check("mr_cnt1", cnt1, '0);
    check("mr_cnt2", cnt2, '0);
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive(0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
